// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, memwrite codes and
// the owner id of the access currently in flight.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] MW_READ = 2'b00;
    localparam logic [1:0] MW_WORD = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_BYTE = 2'b11;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_LDR  = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational arbiter; on a tie it grants the port not served last
// when fair is set, otherwise the core.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic       c_req,
    input  logic       l_req,
    input  owner_e     last,
    input  logic       fair,
    output logic [1:0] grant
);

    // grant[0] = core, grant[1] = loader; at most one bit set.
    always_comb begin
        grant = 2'b00;
        if (c_req && l_req) begin
            grant = (fair && (last == OWN_CORE)) ? 2'b10 : 2'b01;
        end else if (c_req) begin
            grant = 2'b01;
        end else if (l_req) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported synchronous data memory between the core and the
// loader, running each access through issue, latency wait and a response cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1,
    parameter int FAIR    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic [1:0]    c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ready,
    output logic          c_stall,
    input  logic          l_req,
    input  logic [1:0]    l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic [DW-1:0] l_rdata,
    output logic          l_ready,
    output logic          m_en,
    output logic [1:0]    m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output state_e        dbg_state
);

    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);
    localparam logic       FAIR_EN  = (FAIR != 0);

    // Handshake: a requester holds req and its fields until it sees its
    // one-cycle ready; fields are sampled only at grant, and a req still high
    // when the FSM is back in IDLE is a new request.

    state_e        state, state_nx;
    owner_e        own, last_own;
    logic [1:0]    cnt;
    logic [1:0]    lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [DW-1:0] c_rdata_q, l_rdata_q;
    logic [1:0]    grant;

    rr_arbiter2 u_arb (
        .c_req (c_req),
        .l_req (l_req),
        .last  (last_own),
        .fair  (FAIR_EN),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        m_en     = 1'b0;
        c_ready  = 1'b0;
        l_ready  = 1'b0;
        unique case (state)
            IDLE:  if (grant != 2'b00) state_nx = ISSUE;
            ISSUE: begin
                m_en     = 1'b1;
                state_nx = WAIT;
            end
            WAIT:  if (cnt == 2'd0) state_nx = RESP;
            RESP: begin
                c_ready  = (own == OWN_CORE);
                l_ready  = (own == OWN_LDR);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            own       <= OWN_CORE;
            last_own  <= OWN_LDR;
            cnt       <= 2'd0;
            lat_we    <= MW_READ;
            lat_addr  <= '0;
            lat_wdata <= '0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant[0]) begin
                        own       <= OWN_CORE;
                        last_own  <= OWN_CORE;
                        lat_we    <= c_we;
                        lat_addr  <= c_addr;
                        lat_wdata <= c_wdata;
                    end else if (grant[1]) begin
                        own       <= OWN_LDR;
                        last_own  <= OWN_LDR;
                        lat_we    <= l_we;
                        lat_addr  <= l_addr;
                        lat_wdata <= l_wdata;
                    end
                end
                ISSUE: cnt <= LAT_LOAD;
                WAIT: begin
                    if (cnt == 2'd0) begin
                        // Writes pass through WAIT too but leave rdata alone.
                        if (lat_we == MW_READ) begin
                            if (own == OWN_CORE) c_rdata_q <= m_rdata;
                            else                 l_rdata_q <= m_rdata;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_we      = lat_we;
    assign m_addr    = lat_addr;
    assign m_wdata   = lat_wdata;
    assign c_rdata   = c_rdata_q;
    assign l_rdata   = l_rdata_q;
    assign c_stall   = c_req & ~c_ready;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (LAT1/fair, LAT3/fair, LAT1/core-first),
// a timeline model per instance checked every cycle, plus directed literal checks.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tb_cyc = 0;
  int   checks = 0;
  int   failures = 0;

  // per-instance, per-port (0 = core, 1 = loader) signals
  logic        req   [3][2];
  logic [1:0]  we    [3][2];
  logic [31:0] addr  [3][2];
  logic [31:0] wdata [3][2];
  logic [31:0] rdata [3][2];
  logic        ready [3][2];
  logic        stall [3];
  logic        m_en  [3];
  logic [1:0]  m_we  [3];
  logic [31:0] m_addr[3];
  logic [31:0] m_wdata[3];
  logic        busy  [3];
  state_e      dbg   [3];
  bit   [31:0] rseq  [3];
  int          rcnt  [3];

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  function automatic logic [31:0] base(input logic [7:0] i);
    if (i == 8'd16) return 32'hDEADBEEF;
    return {i, 8'h5A, ~i, 8'hC3};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] w, input logic [31:0] d);
    case (w)
      MW_WORD: return d;
      MW_HALF: return {old[31:16], d[15:0]};
      MW_BYTE: return {old[31:8], d[7:0]};
      default: return old;
    endcase
  endfunction

  function automatic bit pick_ldr(input logic c, input logic l, input bit last_l, input int fr);
    if (c && l) return (fr != 0) && !last_l;
    return !c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int LAT = (g == 1) ? 3 : 1;
    localparam int FR  = (g == 2) ? 0 : 1;

    bit [31:0] env_mem [256];
    bit        env_wr  [256];
    bit [31:0] pipe    [4];
    bit [31:0] ref_mem [256];
    bit        ref_wr  [256];

    dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .FAIR(FR)) u_dut (
      .clk(clk), .reset(reset),
      .c_req(req[g][0]), .c_we(we[g][0]), .c_addr(addr[g][0]), .c_wdata(wdata[g][0]),
      .c_rdata(rdata[g][0]), .c_ready(ready[g][0]), .c_stall(stall[g]),
      .l_req(req[g][1]), .l_we(we[g][1]), .l_addr(addr[g][1]), .l_wdata(wdata[g][1]),
      .l_rdata(rdata[g][1]), .l_ready(ready[g][1]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_rdata(pipe[LAT-1]), .busy(busy[g]), .dbg_state(dbg[g])
    );

    // memory environment: read data valid LAT cycles after the enable edge
    always @(posedge clk) begin
      for (int i = 3; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= 32'h0;
      if (m_en[g]) begin
        pipe[0] <= env_wr[m_addr[g][9:2]] ? env_mem[m_addr[g][9:2]] : base(m_addr[g][9:2]);
        if (m_we[g] != MW_READ) begin
          env_mem[m_addr[g][9:2]] <= merge(env_wr[m_addr[g][9:2]] ? env_mem[m_addr[g][9:2]]
                                           : base(m_addr[g][9:2]), m_we[g], m_wdata[g]);
          env_wr[m_addr[g][9:2]] <= 1'b1;
        end
      end
    end

    // timeline model: grant at cycle gc -> issue gc+1, ready gc+2+LAT, free gc+3+LAT
    bit          act = 1'b0;
    int          mc = 0;
    int          gc = 0;
    bit          own = 1'b0;
    bit          last_l = 1'b1;
    logic [1:0]  lwe = 2'b00;
    logic [31:0] laddr = 32'h0;
    logic [31:0] lwd = 32'h0;
    logic [31:0] er_c = 32'h0;
    logic [31:0] er_l = 32'h0;

    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        act    <= 1'b0;
        er_c   <= 32'h0;
        er_l   <= 32'h0;
        last_l <= 1'b1;
      end else begin
        if (act && mc == gc + 1 && lwe != MW_READ) begin
          ref_mem[laddr[9:2]] <= merge(ref_wr[laddr[9:2]] ? ref_mem[laddr[9:2]] : base(laddr[9:2]), lwe, lwd);
          ref_wr[laddr[9:2]]  <= 1'b1;
        end
        if (act && mc == gc + 1 + LAT && lwe == MW_READ) begin
          if (own) er_l <= ref_wr[laddr[9:2]] ? ref_mem[laddr[9:2]] : base(laddr[9:2]);
          else     er_c <= ref_wr[laddr[9:2]] ? ref_mem[laddr[9:2]] : base(laddr[9:2]);
        end
        if ((!act || mc >= gc + 3 + LAT) && (req[g][0] || req[g][1])) begin
          act <= 1'b1;
          gc  <= mc;
          if (pick_ldr(req[g][0], req[g][1], last_l, FR)) begin
            own <= 1'b1; last_l <= 1'b1;
            lwe <= we[g][1]; laddr <= addr[g][1]; lwd <= wdata[g][1];
          end else begin
            own <= 1'b0; last_l <= 1'b0;
            lwe <= we[g][0]; laddr <= addr[g][0]; lwd <= wdata[g][0];
          end
        end
        mc <= mc + 1;
      end
    end

    always @(negedge clk) begin
      bit e_en, e_rsp, e_busy;
      state_e e_st;
      if (!reset) begin
        chk($sformatf("i%0d_rst_busy", g), 32'(busy[g]), 32'h0);
        chk($sformatf("i%0d_rst_m_en", g), 32'(m_en[g]), 32'h0);
        chk($sformatf("i%0d_rst_c_ready", g), 32'(ready[g][0]), 32'h0);
        chk($sformatf("i%0d_rst_l_ready", g), 32'(ready[g][1]), 32'h0);
        chk($sformatf("i%0d_rst_c_rdata", g), rdata[g][0], 32'h0);
        chk($sformatf("i%0d_rst_l_rdata", g), rdata[g][1], 32'h0);
        chk($sformatf("i%0d_rst_m_addr", g), m_addr[g], 32'h0);
        chk($sformatf("i%0d_rst_state", g), 32'(dbg[g]), 32'(IDLE));
      end else begin
        e_en   = act && (mc == gc + 1);
        e_rsp  = act && (mc == gc + 2 + LAT);
        e_busy = act && (mc >= gc + 1) && (mc <= gc + 2 + LAT);
        e_st   = e_en ? ISSUE : (e_rsp ? RESP : (e_busy ? WAIT : IDLE));
        chk($sformatf("i%0d_m_en@%0d", g, mc), 32'(m_en[g]), 32'(e_en));
        chk($sformatf("i%0d_busy@%0d", g, mc), 32'(busy[g]), 32'(e_busy));
        chk($sformatf("i%0d_c_ready@%0d", g, mc), 32'(ready[g][0]), 32'(e_rsp && !own));
        chk($sformatf("i%0d_l_ready@%0d", g, mc), 32'(ready[g][1]), 32'(e_rsp && own));
        chk($sformatf("i%0d_c_stall@%0d", g, mc), 32'(stall[g]), 32'(req[g][0] && !(e_rsp && !own)));
        chk($sformatf("i%0d_state@%0d", g, mc), 32'(dbg[g]), 32'(e_st));
        chk($sformatf("i%0d_c_rdata@%0d", g, mc), rdata[g][0], er_c);
        chk($sformatf("i%0d_l_rdata@%0d", g, mc), rdata[g][1], er_l);
        if (e_en) begin
          chk($sformatf("i%0d_m_we@%0d", g, mc), 32'(m_we[g]), 32'(lwe));
          chk($sformatf("i%0d_m_addr@%0d", g, mc), m_addr[g], laddr);
          chk($sformatf("i%0d_m_wdata@%0d", g, mc), m_wdata[g], lwd);
        end
      end
    end

    // order of completions: 0 = core, 1 = loader
    always @(negedge clk) begin
      if (reset && ready[g][0]) begin
        rseq[g] <= {rseq[g][30:0], 1'b0};
        rcnt[g] <= rcnt[g] + 1;
      end else if (reset && ready[g][1]) begin
        rseq[g] <= {rseq[g][30:0], 1'b1};
        rcnt[g] <= rcnt[g] + 1;
      end
    end
  end

  task automatic port_access(input int k, input int p, input logic [1:0] w, input logic [31:0] a,
                             input logic [31:0] d, input bit keep, output int done);
    done = -1;
    we[k][p] = w; addr[k][p] = a; wdata[k][p] = d; req[k][p] = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready[k][p]) begin
        done = tb_cyc;
        break;
      end
    end
    if (done < 0) begin
      checks++;
      failures++;
      $display("FAIL access_timeout inst=%0d port=%0d: got no ready, expected one within 40 cycles", k, p);
    end
    @(posedge clk); #1;
    if (!keep) req[k][p] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, tc, tl, first, n0, n2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        req[k][p] = 1'b0; we[k][p] = MW_READ; addr[k][p] = 32'h0; wdata[k][p] = 32'h0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy[0]), 32'h0);
    chk("reset_c_rdata", rdata[0][0], 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // core read of 0x40, MEM_LAT=1: pin the cycle-by-cycle timeline
    we[0][0] = MW_READ; addr[0][0] = 32'h40; req[0][0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t1_m_en_c%0d", i), 32'(m_en[0]), 32'(i == 1));
      chk($sformatf("t1_ready_c%0d", i), 32'(ready[0][0]), 32'(i == 3));
      chk($sformatf("t1_stall_c%0d", i), 32'(stall[0]), 32'(i <= 2));
      chk($sformatf("t1_busy_c%0d", i), 32'(busy[0]), 32'(i >= 1 && i <= 3));
      if (i == 3) begin
        chk("t1_c_rdata", rdata[0][0], 32'hDEADBEEF);
        @(posedge clk); #1 req[0][0] = 1'b0;
      end
    end

    // simultaneous requests right after reset: core wins the first tie
    pulse_reset();
    t0 = tb_cyc;
    fork
      port_access(0, 0, MW_READ, 32'h40, 32'h0, 1'b0, tc);
      port_access(0, 1, MW_READ, 32'h40, 32'h0, 1'b0, tl);
    join
    chk("t2_c_ready_cycle", 32'(tc - t0), 32'd3);
    chk("t2_l_ready_cycle", 32'(tl - t0), 32'd7);
    chk("t2_l_rdata", rdata[0][1], 32'hDEADBEEF);

    // loader word write then core read-back; loader rdata untouched by write
    port_access(0, 1, MW_WORD, 32'h100, 32'h12345678, 1'b0, tl);
    port_access(0, 0, MW_READ, 32'h100, 32'h0, 1'b0, tc);
    chk("t3_c_rdata", rdata[0][0], 32'h12345678);
    chk("t3_l_rdata", rdata[0][1], 32'hDEADBEEF);

    // both ports continuously busy: fair alternates, core-first starves loader
    pulse_reset();
    n0 = rcnt[0];
    n2 = rcnt[2];
    fork
      for (int i = 0; i < 3; i++) port_access(0, 0, MW_READ, 32'h10 + 32'(4 * i), 32'h0, i < 2, tc);
      for (int i = 0; i < 3; i++) port_access(0, 1, MW_READ, 32'h80 + 32'(4 * i), 32'h0, i < 2, tl);
      for (int i = 0; i < 3; i++) port_access(2, 0, MW_READ, 32'h10 + 32'(4 * i), 32'h0, i < 2, first);
      for (int i = 0; i < 3; i++) port_access(2, 1, MW_READ, 32'h80 + 32'(4 * i), 32'h0, i < 2, t0);
    join
    chk("t4_fair_count", 32'(rcnt[0] - n0), 32'd6);
    chk("t4_fair_order", 32'(rseq[0][5:0]), 32'b010101);
    chk("t4_nofair_count", 32'(rcnt[2] - n2), 32'd6);
    chk("t4_nofair_order", 32'(rseq[2][5:0]), 32'b000111);

    // MEM_LAT=3 core byte write, then read-back of the merged word
    we[1][0] = MW_BYTE; addr[1][0] = 32'h20; wdata[1][0] = 32'hAABBCCDD; req[1][0] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("t5_m_en_issue", 32'(m_en[1]), 32'h1);
        chk("t5_m_we_issue", 32'(m_we[1]), 32'(MW_BYTE));
      end
      chk($sformatf("t5_ready_c%0d", i), 32'(ready[1][0]), 32'(i == 5));
      if (i == 5) begin
        chk("t5_c_rdata_kept", rdata[1][0], 32'h0);
        @(posedge clk); #1 req[1][0] = 1'b0;
      end
    end
    port_access(1, 0, MW_READ, 32'h20, 32'h0, 1'b0, tc);
    chk("t5_readback", rdata[1][0], 32'h085AF7DD);

    // reset during WAIT of a core read; the read is reissued afterwards
    we[0][0] = MW_READ; addr[0][0] = 32'h44; req[0][0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_busy_zero", 32'(busy[0]), 32'h0);
    chk("t6_m_en_zero", 32'(m_en[0]), 32'h0);
    chk("t6_ready_zero", 32'(ready[0][0]), 32'h0);
    chk("t6_c_rdata_zero", rdata[0][0], 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready[0][0]) begin
        first = i;
        break;
      end
    end
    @(posedge clk); #1 req[0][0] = 1'b0;
    chk("t6_reissue_ready_cycle", 32'(first), 32'd3);
    chk("t6_reissue_rdata", rdata[0][0], 32'h115AEEC3);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
